// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared constants and types for the systolic-array result drain path
package sa_pkg;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 8;
  localparam int TILE_DIM   = 4;
  localparam int TILE_ELEMS = TILE_DIM * TILE_DIM;

  typedef enum logic {IDLE, DRAIN} drain_state_e;
  typedef logic [3:0] elem_idx_t;
endpackage

// File: rtl/result_tile_bank.sv
// rtl/result_tile_bank.sv - 2-entry tile store: whole-tile write, single-element read
module result_tile_bank
  import sa_pkg::*;
(
  input  logic                         clk,
  input  logic                         we_i,
  input  logic                         wsel_i,
  input  logic [TILE_ELEMS*DATA_W-1:0] wtile_i,
  input  logic [ADDR_W-1:0]            wbase_i,
  input  logic                         rsel_i,
  input  elem_idx_t                    ridx_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic [ADDR_W-1:0]            rbase_o
);
  logic [TILE_ELEMS*DATA_W-1:0] tile_q [2];
  logic [ADDR_W-1:0]            base_q [2];

  // Payload needs no reset: occupancy is tracked by the pointers/count in the top level.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tile_q[wsel_i] <= wtile_i;
      base_q[wsel_i] <= wbase_i;
    end
  end

  assign rdata_o = tile_q[rsel_i][ridx_i*DATA_W +: DATA_W];
  assign rbase_o = base_q[rsel_i];
endmodule

// File: rtl/result_drain_buffer.sv
// rtl/result_drain_buffer.sv - 2-deep tile buffer draining 4x4 result tiles as a word stream
// DRAIN_RELU_EN: when defined, negative output words are clamped to 0 at the write port.
module result_drain_buffer
  import sa_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         capture_i,
  input  logic [ADDR_W-1:0]            base_i,
  input  logic [TILE_ELEMS*DATA_W-1:0] tile_i,
  input  logic                         done_i,
  input  logic                         clear_i,
  output logic                         wr_valid_o,
  input  logic                         wr_ready_i,
  output logic [ADDR_W-1:0]            wr_addr_o,
  output logic [DATA_W-1:0]            wr_data_o,
  output logic                         busy_o,
  output logic                         overflow_o,
  output logic                         all_done_o
);
  drain_state_e state_q;
  elem_idx_t    idx_q;
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q, count_d, cnt_after_free;
  logic         valid_q, overflow_q, pend_done_q;
  logic         accept, last, cap_ok;
  logic [DATA_W-1:0] elem;
  logic [ADDR_W-1:0] base;

  result_tile_bank u_bank (
    .clk     (clk),
    .we_i    (cap_ok & ~clear_i),
    .wsel_i  (wr_ptr_q),
    .wtile_i (tile_i),
    .wbase_i (base_i),
    .rsel_i  (rd_ptr_q),
    .ridx_i  (idx_q),
    .rdata_o (elem),
    .rbase_o (base)
  );

  // A bank freed by the final accept is reusable by a capture in the same cycle.
  always_comb begin
    accept         = valid_q & wr_ready_i;
    last           = accept & (idx_q == elem_idx_t'(TILE_ELEMS - 1));
    cnt_after_free = count_q - {1'b0, last};
    cap_ok         = capture_i & (cnt_after_free != 2'd2);
    count_d        = cnt_after_free + {1'b0, cap_ok};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      pend_done_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      pend_done_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (cap_ok) wr_ptr_q <= ~wr_ptr_q;
      if (last) rd_ptr_q <= ~rd_ptr_q;
      if (capture_i && !cap_ok) overflow_q <= 1'b1;
      if (done_i) pend_done_q <= 1'b1;
      else if (cap_ok) pend_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (count_q != 2'd0) begin
            state_q <= DRAIN;
            valid_q <= 1'b1;
            idx_q   <= '0;
          end
        end
        DRAIN: begin
          if (accept) begin
            if (last) begin
              idx_q <= '0;
              if (count_d == 2'd0) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_addr_o = '0;
    wr_data_o = '0;
    if (valid_q) begin
      wr_addr_o = base + ADDR_W'(idx_q);
`ifdef DRAIN_RELU_EN
      wr_data_o = elem[DATA_W-1] ? '0 : elem;
`else
      wr_data_o = elem;
`endif
    end
  end

  assign wr_valid_o = valid_q;
  assign busy_o     = (count_q != 2'd0);
  assign overflow_o = overflow_q;
  assign all_done_o = pend_done_q & (count_q == 2'd0) & ~valid_q;
endmodule

// File: tb/tb_result_drain_buffer.sv
// tb/tb_result_drain_buffer.sv - scoreboard bench for result_drain_buffer
module tb_result_drain_buffer;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         capture_i = 1'b0;
  logic [7:0]   base_i = '0;
  logic [255:0] tile_i = '0;
  logic         done_i = 1'b0;
  logic         clear_i = 1'b0;
  logic         wr_ready_i = 1'b0;
  logic         wr_valid_o, busy_o, overflow_o, all_done_o;
  logic [7:0]   wr_addr_o;
  logic [15:0]  wr_data_o;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] seen_data [256];
  logic        stall = 1'b0;
  logic [7:0]  st_a;
  logic [15:0] st_d;
  logic [255:0] t;
  int          tiles_left;

  result_drain_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .capture_i  (capture_i),
    .base_i     (base_i),
    .tile_i     (tile_i),
    .done_i     (done_i),
    .clear_i    (clear_i),
    .wr_valid_o (wr_valid_o),
    .wr_ready_i (wr_ready_i),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o),
    .all_done_o (all_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [15:0] v);
`ifdef DRAIN_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_tile();
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'($urandom);
    return r;
  endfunction

  task automatic capture(input logic [7:0] b, input logic [255:0] tl, input bit accepted);
    wr_t e;
    capture_i = 1'b1;
    base_i    = b;
    tile_i    = tl;
    if (accepted) begin
      for (int k = 0; k < 16; k++) begin
        e.a = b + 8'(k);
        e.d = model_word(tl[k*16 +: 16]);
        exp_q.push_back(e);
      end
    end
    step();
    capture_i = 1'b0;
  endtask

  // Monitor: a transfer seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    if (!rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", {31'b0, wr_valid_o}, 32'd1);
        chk("hold_addr", {24'b0, wr_addr_o}, {24'b0, st_a});
        chk("hold_data", {16'b0, wr_data_o}, {16'b0, st_d});
      end
      if (wr_valid_o && wr_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {24'b0, wr_addr_o}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", {24'b0, wr_addr_o}, {24'b0, mon_e.a});
          chk("wr_data", {16'b0, wr_data_o}, {16'b0, mon_e.d});
        end
        seen_data[wr_addr_o] = wr_data_o;
      end
      stall = wr_valid_o && !wr_ready_i;
      st_a  = wr_addr_o;
      st_d  = wr_data_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, wr_valid_o}, 32'd0);
    chk("rst_addr", {24'b0, wr_addr_o}, 32'd0);
    chk("rst_data", {16'b0, wr_data_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_ovf", {31'b0, overflow_o}, 32'd0);
    chk("rst_alldone", {31'b0, all_done_o}, 32'd0);
    rst = 1'b1;
    step();

    // Single tile, data 1..16 at 0x20..0x2F
    wr_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) t[k*16 +: 16] = 16'(k + 1);
    capture(8'h20, t, 1'b1);
    chk("lat_pre", {31'b0, wr_valid_o}, 32'd0);
    step();
    chk("lat_valid", {31'b0, wr_valid_o}, 32'd1);
    chk("first_addr", {24'b0, wr_addr_o}, 32'h20);
    repeat (16) step();
    chk("single_len", {31'b0, wr_valid_o}, 32'd0);
    chk("single_drained", exp_q.size(), 32'd0);
    chk("single_word15", {16'b0, seen_data[8'h2F]}, 32'd16);

    // Backpressure 1,0,0 repeating
    wr_ready_i = 1'b0;
    capture(8'h90, rand_tile(), 1'b1);
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      wr_ready_i = (c % 3 == 0);
      step();
    end
    chk("bp_drained", exp_q.size(), 32'd0);
    chk("bp_idle", {31'b0, wr_valid_o}, 32'd0);

    // Overflow: two accepted, third dropped, then back-to-back drain
    wr_ready_i = 1'b0;
    capture(8'hA0, rand_tile(), 1'b1);
    capture(8'hB0, rand_tile(), 1'b1);
    capture(8'hC0, rand_tile(), 1'b0);
    chk("ovf_set", {31'b0, overflow_o}, 32'd1);
    chk("ovf_busy", {31'b0, busy_o}, 32'd1);
    wr_ready_i = 1'b1;
    repeat (32) step();
    chk("no_gap_valid", {31'b0, wr_valid_o}, 32'd0);
    chk("no_gap_drained", exp_q.size(), 32'd0);
    chk("ovf_sticky", {31'b0, overflow_o}, 32'd1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("ovf_cleared", {31'b0, overflow_o}, 32'd0);

    // Address wrap plus done during drain
    capture(8'hF8, rand_tile(), 1'b1);
    repeat (3) step();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk("alldone_early", {31'b0, all_done_o}, 32'd0);
    for (int c = 0; c < 40 && wr_valid_o; c++) step();
    chk("wrap_end", {31'b0, wr_valid_o}, 32'd0);
    chk("alldone_set", {31'b0, all_done_o}, 32'd1);
    chk("wrap_idle_busy", {31'b0, busy_o}, 32'd0);
    chk("wrap_word_ff", exp_q.size(), 32'd0);
    capture(8'h10, rand_tile(), 1'b1);
    chk("alldone_on_cap", {31'b0, all_done_o}, 32'd0);
    step();
    for (int c = 0; c < 40 && wr_valid_o; c++) step();
    chk("pend_cleared", {31'b0, all_done_o}, 32'd0);

    // Negative element at index 5
    t = rand_tile();
    t[5*16 +: 16] = 16'hFFFB;
    capture(8'h40, t, 1'b1);
    step();
    for (int c = 0; c < 40 && wr_valid_o; c++) step();
`ifdef DRAIN_RELU_EN
    chk("neg_elem", {16'b0, seen_data[8'h45]}, 32'h0000);
`else
    chk("neg_elem", {16'b0, seen_data[8'h45]}, 32'hFFFB);
`endif

    // Randomized traffic with random backpressure
    tiles_left = 8;
    for (int c = 0; c < 3000 && (tiles_left > 0 || exp_q.size() > 0); c++) begin
      wr_ready_i = ($urandom_range(0, 9) < 6);
      if (tiles_left > 0 && exp_q.size() <= 16 && $urandom_range(0, 2) == 0) begin
        capture(8'($urandom), rand_tile(), 1'b1);
        tiles_left--;
      end else begin
        step();
      end
    end
    chk("rand_drained", exp_q.size(), 32'd0);
    chk("rand_tiles", tiles_left, 32'd0);

    // Reset mid-drain after 7 words accepted
    wr_ready_i = 1'b1;
    step();
    capture(8'h60, rand_tile(), 1'b1);
    for (int c = 0; c < 40 && exp_q.size() > 9; c++) step();
    chk("mid_count", exp_q.size(), 32'd9);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, wr_valid_o}, 32'd0);
    chk("mid_rst_addr", {24'b0, wr_addr_o}, 32'd0);
    chk("mid_rst_data", {16'b0, wr_data_o}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    exp_q.delete();
    step();
    step();
    rst = 1'b1;
    repeat (20) step();
    chk("no_writes_after_rst", {31'b0, wr_valid_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
